// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN engine partial-sum path.
package cnn_pkg;

  // Window FSM: IDLE has no open window, ACC is mid-window.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

  // Accumulator width. It holds a full window of full-scale products without
  // wrapping: 2*data_width bits per product, plus log2(products per window).
  function automatic int acc_width(input int data_width, input int num_pe,
                                   input int max_len);
    return 2 * data_width + $clog2(num_pe * max_len);
  endfunction

endpackage

// File: rtl/psum_adder_tree.sv
// Combinational reduction of one beat of PE products.
// Each lane is sign-extended to the accumulator width before it is summed.
module psum_adder_tree
  import cnn_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int NUM_PE    = 3,
  parameter int ACC_W     = acc_width(DataWidth, NUM_PE, 16)
) (
  input  logic [NUM_PE*2*DataWidth-1:0] in_p,
  output logic signed [ACC_W-1:0]       sum
);

  localparam int PW = 2 * DataWidth;

  // Sign-extend every lane and add it into the running total.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      sum = sum + ACC_W'($signed(in_p[i*PW +: PW]));
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for one PE row. Each beat is reduced by the adder
// tree, the reduced sums are accumulated over a window of len beats, ReLU is
// optional, and one result per window is presented on a valid/ready output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no open window; the next accepted beat opens one (len/relu sampled)
// ACC   | window open; cnt beats accepted so far, waiting for beat len_q
module psum_accumulator
  import cnn_pkg::*;
#(
  parameter  int DataWidth = 8,
  parameter  int NUM_PE    = 3,
  parameter  int MAX_LEN   = 16,
  localparam int ACC_W     = acc_width(DataWidth, NUM_PE, MAX_LEN),
  localparam int LEN_W     = $clog2(MAX_LEN) + 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [LEN_W-1:0]              len,
  input  logic                          relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_PE*2*DataWidth-1:0] in_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       out_sum
);

  logic                    adv;
  logic                    accept;
  logic [LEN_W-1:0]        len_eff;

  acc_state_t              state;
  acc_state_t              state_n;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        cnt_n;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_q_n;
  logic                    relu_q;
  logic                    relu_q_n;
  logic                    tag_first;
  logic                    tag_last;
  logic                    tag_relu;

  logic signed [ACC_W-1:0] tree_sum;
  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_sum;
  logic                    s1_first;
  logic                    s1_last;
  logic                    s1_relu;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] total;

  // The whole pipe moves together: it advances unless a result is waiting.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
    accept   = in_valid && adv;
    len_eff  = (len == '0) ? LEN_W'(1) : len;
  end

  psum_adder_tree #(
    .DataWidth (DataWidth),
    .NUM_PE    (NUM_PE),
    .ACC_W     (ACC_W)
  ) u_tree (
    .in_p (in_p),
    .sum  (tree_sum)
  );

  // Window FSM next state, plus first/last/relu tags for the beat being offered.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    len_q_n   = len_q;
    relu_q_n  = relu_q;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    tag_relu  = relu_q;
    case (state)
      IDLE: begin
        tag_first = 1'b1;
        tag_relu  = relu_en;
        tag_last  = (len_eff == LEN_W'(1));
        if (accept) begin
          len_q_n  = len_eff;
          relu_q_n = relu_en;
          if (len_eff != LEN_W'(1)) begin
            cnt_n   = LEN_W'(1);
            state_n = ACC;
          end
        end
      end
      ACC: begin
        tag_last = ((cnt + LEN_W'(1)) == len_q);
        if (accept) begin
          if (tag_last) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + LEN_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM registers; when the pipe is stalled they hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= LEN_W'(1);
      relu_q <= 1'b0;
    end else if (adv) begin
      state  <= state_n;
      cnt    <= cnt_n;
      len_q  <= len_q_n;
      relu_q <= relu_q_n;
    end
  end

  // Stage 1: register the reduced beat and its window tags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s1_sum   <= tree_sum;
      s1_first <= tag_first;
      s1_last  <= tag_last;
      s1_relu  <= tag_relu;
    end
  end

  // A first beat ignores whatever the accumulator holds from the last window.
  always_comb begin
    total = (s1_first ? '0 : acc) + s1_sum;
  end

  // Stage 2: accumulate, and on the last beat publish the (optionally clamped) total.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (adv) begin
      if (s1_valid && s1_last) begin
        out_sum   <= (s1_relu && total[ACC_W-1]) ? '0 : total;
        out_valid <= 1'b1;
        acc       <= '0;
      end else begin
        out_valid <= 1'b0;
        if (s1_valid) begin
          acc <= total;
        end
      end
    end
  end

endmodule
